// File: rtl/toast_timer.sv
// Toast countdown: loads a clamped duration as BCD mm:s:s, decrements once per CLK_HZ cycles in RUN.
// All outputs registered; write_ack one cycle after an accepted load, done one cycle after reaching 000.
module toast_timer #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int MAX_SEC = 599
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        write,
  input  logic [9:0]  Time,
  input  logic        start,
  input  logic        stop,
  output logic        write_ack,
  output logic [11:0] tLED,
  output logic        heat_en,
  output logic        done
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  state_t        state;
  logic [PW-1:0] presc;
  logic          load;
  logic          tick;
  logic [9:0]    t_clamp;
  logic [11:0]   t_bcd;
  logic [11:0]   t_dec;

  always_comb begin
    // write is ignored while the previous ack is still up, so a late drop cannot reload
    load    = write & ~write_ack;
    tick    = (presc == PW'(CLK_HZ - 1));
    t_clamp = (32'(Time) > MAX_SEC) ? 10'(MAX_SEC) : Time;
    t_bcd   = {4'(t_clamp / 10'd60), 4'((t_clamp % 10'd60) / 10'd10), 4'(t_clamp % 10'd10)};
  end

  always_comb begin
    t_dec = tLED;
    if (tLED[3:0] != 4'd0) begin
      t_dec[3:0] = tLED[3:0] - 4'd1;
    end else begin
      t_dec[3:0] = 4'd9;
      if (tLED[7:4] != 4'd0) begin
        t_dec[7:4] = tLED[7:4] - 4'd1;
      end else begin
        t_dec[7:4]  = 4'd5;
        t_dec[11:8] = tLED[11:8] - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      presc     <= '0;
      write_ack <= 1'b0;
      tLED      <= '0;
      heat_en   <= 1'b0;
      done      <= 1'b0;
    end else begin
      write_ack <= load;
      done      <= 1'b0;
      if (load) begin
        tLED  <= t_bcd;
        presc <= '0;
      end
      if (stop) begin
        state   <= IDLE;
        presc   <= '0;
        heat_en <= 1'b0;
      end else if (state == IDLE) begin
        if (start) begin
          state   <= RUN;
          presc   <= '0;
          heat_en <= 1'b1;
        end
      end else if (!start) begin
        state   <= IDLE;
        presc   <= '0;
        heat_en <= 1'b0;
      end else if (!load) begin
        // expiry does not wait for a tick; a load in the same cycle takes precedence
        if (tLED == 12'h000) begin
          done    <= 1'b1;
          state   <= IDLE;
          heat_en <= 1'b0;
        end else if (tick) begin
          tLED  <= t_dec;
          presc <= '0;
        end else begin
          presc <= presc + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_toast_timer.sv
// Bench for toast_timer: directed scenarios plus random traffic, scored against an integer-seconds model.
module tb_toast_timer;

  localparam int CLK_HZ  = 4;
  localparam int MAX_SEC = 599;

  logic        clk = 1'b0;
  logic        reset;
  logic        write;
  logic [9:0]  Time;
  logic        start;
  logic        stop;
  logic        write_ack;
  logic [11:0] tLED;
  logic        heat_en;
  logic        done;

  int checks = 0;
  int errors = 0;

  // reference model: remaining time kept as a plain count of seconds
  int m_secs;
  int m_presc;
  bit m_run;
  bit m_ack;
  bit m_done;

  toast_timer #(.CLK_HZ(CLK_HZ), .MAX_SEC(MAX_SEC)) dut (
    .clk(clk), .reset(reset), .write(write), .Time(Time), .start(start), .stop(stop),
    .write_ack(write_ack), .tLED(tLED), .heat_en(heat_en), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int to_bcd(input int s);
    return ((s / 60) << 8) | (((s % 60) / 10) << 4) | (s % 10);
  endfunction

  task automatic model_reset();
    m_secs = 0; m_presc = 0; m_run = 0; m_ack = 0; m_done = 0;
  endtask

  task automatic model_step();
    bit ld;
    bit run_n;
    int sec_n;
    int p_n;
    ld     = write && !m_ack;
    run_n  = m_run;
    sec_n  = m_secs;
    p_n    = m_presc;
    m_done = 0;
    if (ld) begin
      sec_n = (int'(Time) > MAX_SEC) ? MAX_SEC : int'(Time);
      p_n   = 0;
    end
    if (stop) begin
      run_n = 0; p_n = 0;
    end else if (!m_run) begin
      if (start) begin run_n = 1; p_n = 0; end
    end else if (!start) begin
      run_n = 0; p_n = 0;
    end else if (!ld) begin
      if (m_secs == 0) begin
        m_done = 1; run_n = 0;
      end else if (m_presc == CLK_HZ - 1) begin
        sec_n = m_secs - 1; p_n = 0;
      end else begin
        p_n = m_presc + 1;
      end
    end
    m_ack   = ld;
    m_run   = run_n;
    m_secs  = sec_n;
    m_presc = p_n;
  endtask

  // one clock: model advances on the edge, DUT outputs compared on the falling edge
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("ack", int'(write_ack), int'(m_ack));
    chk("tled", int'(tLED), to_bcd(m_secs));
    chk("heat", int'(heat_en), int'(m_run));
    chk("done", int'(done), int'(m_done));
  endtask

  task automatic do_load(input int v);
    bit got;
    got   = 0;
    write = 1'b1;
    Time  = 10'(v);
    for (int k = 0; k < 4 && !got; k++) begin
      tick();
      if (write_ack) got = 1;
    end
    chk("load_timeout", int'(got), 1);
    write = 1'b0;
  endtask

  initial begin
    bit late;
    reset = 1'b1; write = 1'b0; Time = '0; start = 1'b0; stop = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_tled", int'(tLED), 0);
    chk("rst_heat", int'(heat_en), 0);
    chk("rst_ack", int'(write_ack), 0);
    chk("rst_done", int'(done), 0);

    // load 75 held across the ack: exactly one ack
    write = 1'b1; Time = 10'd75;
    tick();
    chk("ld75_ack", int'(write_ack), 1);
    chk("ld75_tled", int'(tLED), 'h115);
    tick();
    chk("ld75_noack", int'(write_ack), 0);
    write = 1'b0;
    tick();

    // full 12 s countdown
    do_load(12);
    start = 1'b1;
    tick();
    chk("run_heat", int'(heat_en), 1);
    repeat (4) tick();
    chk("t12_011", int'(tLED), 'h011);
    repeat (4) tick();
    chk("t12_010", int'(tLED), 'h010);
    repeat (40) tick();
    chk("t12_000", int'(tLED), 'h000);
    chk("t12_nodone", int'(done), 0);
    tick();
    chk("t12_done", int'(done), 1);
    chk("t12_heatoff", int'(heat_en), 0);
    start = 1'b0;
    tick();
    chk("t12_pulse", int'(done), 0);

    // borrow cases
    do_load(60);
    start = 1'b1;
    repeat (5) tick();
    chk("b60", int'(tLED), 'h059);
    start = 1'b0;
    tick();
    do_load(10);
    start = 1'b1;
    repeat (5) tick();
    chk("b10", int'(tLED), 'h009);
    start = 1'b0;
    tick();

    // clamp and zero-length load
    do_load(700);
    chk("clamp", int'(tLED), 'h959);
    do_load(0);
    start = 1'b1;
    tick();
    chk("z_heat1", int'(heat_en), 1);
    chk("z_nodone", int'(done), 0);
    tick();
    chk("z_done", int'(done), 1);
    chk("z_heat0", int'(heat_en), 0);
    start = 1'b0;
    tick();

    // stop mid-prescale, then resume with a full prescale period
    do_load(30);
    start = 1'b1;
    repeat (3) tick();
    stop = 1'b1;
    tick();
    chk("stop_heat", int'(heat_en), 0);
    chk("stop_tled", int'(tLED), 'h030);
    repeat (5) tick();
    chk("stop_hold", int'(tLED), 'h030);
    stop = 1'b0;
    tick();
    repeat (3) tick();
    chk("resume_wait", int'(tLED), 'h030);
    tick();
    chk("resume_029", int'(tLED), 'h029);

    // asynchronous reset between edges while running
    repeat (6) tick();
    #2 reset = 1'b1;
    #1;
    chk("arst_tled", int'(tLED), 0);
    chk("arst_heat", int'(heat_en), 0);
    chk("arst_ack", int'(write_ack), 0);
    chk("arst_done", int'(done), 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (6) tick();
    chk("arst_after", int'(tLED), 0);
    start = 1'b0;
    tick();

    // random traffic
    late = 0;
    for (int i = 0; i < 2000; i++) begin
      if (write && write_ack) begin
        late  = ($urandom_range(0, 3) == 0);
        write = late;
      end else if (write && late) begin
        write = 1'b0;
        late  = 0;
      end else if (!write && $urandom_range(0, 19) == 0) begin
        write = 1'b1;
        Time  = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, 8));
      end
      if ($urandom_range(0, 29) == 0) start = ~start;
      stop = ($urandom_range(0, 39) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
